// File: rtl/ppt_pkg.sv
// Shared types and constants for the pulse-train sequencer.
package ppt_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [1:0] FIELD_PERIOD = 2'd0;
   localparam logic [1:0] FIELD_WIDTH  = 2'd1;
   localparam logic [1:0] FIELD_COUNT  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_GAP,
      ST_FIN
   } state_t;

endpackage

// File: rtl/ppt_step_table.sv
// Step profile register file: period/width/count per slot, one write port,
// one combinational read port.
module ppt_step_table
   import ppt_pkg::*;
#(
   parameter  int NUM_STEPS = 4,
   parameter  int CNT_W     = CNT_W_DEF,
   localparam int STEP_W    = $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [STEP_W-1:0] wr_step,
   input  logic [1:0]        wr_field,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic [STEP_W-1:0] rd_step,
   output logic [CNT_W-1:0]  rd_period,
   output logic [CNT_W-1:0]  rd_width,
   output logic [CNT_W-1:0]  rd_count
);

   logic [CNT_W-1:0] period_q [NUM_STEPS];
   logic [CNT_W-1:0] width_q  [NUM_STEPS];
   logic [CNT_W-1:0] count_q  [NUM_STEPS];
   logic [CNT_W-1:0] period_d [NUM_STEPS];
   logic [CNT_W-1:0] width_d  [NUM_STEPS];
   logic [CNT_W-1:0] count_d  [NUM_STEPS];

   always_comb begin
      period_d = period_q;
      width_d  = width_q;
      count_d  = count_q;
      if (we) begin
         case (wr_field)
            FIELD_PERIOD: period_d[wr_step] = wr_data;
            FIELD_WIDTH:  width_d[wr_step]  = wr_data;
            FIELD_COUNT:  count_d[wr_step]  = wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= '{default: '0};
         width_q  <= '{default: '0};
         count_q  <= '{default: '0};
      end else begin
         period_q <= period_d;
         width_q  <= width_d;
         count_q  <= count_d;
      end
   end

   assign rd_period = period_q[rd_step];
   assign rd_width  = width_q[rd_step];
   assign rd_count  = count_q[rd_step];

endmodule

// File: rtl/ppt_sequencer.sv
// Runs the step table as a burst program driving the pulse generator.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch active slot profile, skip it if invalid or empty
// RUN   | generator enabled, counting pulse edges
// GAP   | one cycle with generator off, choose next step
// FIN   | program complete, raise done
module ppt_sequencer
   import ppt_pkg::*;
#(
   parameter  int NUM_STEPS = 4,
   parameter  int CNT_W     = CNT_W_DEF,
   localparam int STEP_W    = $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [STEP_W-1:0] cfg_step,
   input  logic [1:0]        cfg_field,
   input  logic [CNT_W-1:0]  cfg_data,
   input  logic [STEP_W-1:0] num_steps_m1,
   input  logic              loop_en,
   input  logic              start,
   input  logic              abort,
   input  logic              pulse_in,
   output logic              pg_run,
   output logic [CNT_W-1:0]  pg_period,
   output logic [CNT_W-1:0]  pg_width,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [STEP_W-1:0] cur_step,
   output logic [CNT_W-1:0]  step_pulses
);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] cur_step_q, cur_step_d;
   logic [CNT_W-1:0]  step_pulses_q, step_pulses_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  width_q, width_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              pulse_in_q;

   logic [CNT_W-1:0]  tbl_period, tbl_width, tbl_count;
   logic [CNT_W-1:0]  pulses_inc;
   logic              pulse_rise, last_step;
   state_t            adv_state;
   logic [STEP_W-1:0] adv_step;

   ppt_step_table #(.NUM_STEPS(NUM_STEPS), .CNT_W(CNT_W)) u_table (
      .clk       (clk),
      .rst       (rst),
      .we        (cfg_we),
      .wr_step   (cfg_step),
      .wr_field  (cfg_field),
      .wr_data   (cfg_data),
      .rd_step   (cur_step_q),
      .rd_period (tbl_period),
      .rd_width  (tbl_width),
      .rd_count  (tbl_count)
   );

   assign pulse_rise = pulse_in & ~pulse_in_q;
   assign pulses_inc = step_pulses_q + CNT_W'(1);
   assign last_step  = (cur_step_q == num_steps_m1);

   // Shared by GAP and by a skipped step leaving LOAD.
   assign adv_state = (last_step && !loop_en) ? ST_FIN : ST_LOAD;
   assign adv_step  = !last_step ? cur_step_q + STEP_W'(1)
                    : (loop_en ? '0 : cur_step_q);

   always_comb begin
      state_d       = state_q;
      cur_step_d    = cur_step_q;
      step_pulses_d = step_pulses_q;
      period_d      = period_q;
      width_d       = width_q;
      count_d       = count_q;
      done_d        = done_q;
      err_d         = err_q;
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d       = ST_LOAD;
                  cur_step_d    = '0;
                  step_pulses_d = '0;
                  done_d        = 1'b0;
                  err_d         = 1'b0;
               end
            end
            ST_LOAD: begin
               period_d = tbl_period;
               width_d  = tbl_width;
               count_d  = tbl_count;
               if (tbl_count == '0) begin
                  state_d    = adv_state;
                  cur_step_d = adv_step;
               end else if (tbl_width == '0 || tbl_width >= tbl_period) begin
                  state_d    = adv_state;
                  cur_step_d = adv_step;
                  err_d      = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (pulse_rise) begin
                  step_pulses_d = pulses_inc;
                  if (pulses_inc >= count_q) state_d = ST_GAP;
               end
            end
            ST_GAP: begin
               state_d    = adv_state;
               cur_step_d = adv_step;
               if (adv_state == ST_LOAD) step_pulses_d = '0;
            end
            ST_FIN: begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cur_step_q    <= '0;
         step_pulses_q <= '0;
         period_q      <= '0;
         width_q       <= '0;
         count_q       <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         pulse_in_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_step_q    <= cur_step_d;
         step_pulses_q <= step_pulses_d;
         period_q      <= period_d;
         width_q       <= width_d;
         count_q       <= count_d;
         done_q        <= done_d;
         err_q         <= err_d;
         pulse_in_q    <= pulse_in;
      end
   end

   assign pg_run      = (state_q == ST_RUN);
   assign pg_period   = period_q;
   assign pg_width    = width_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign cur_step    = cur_step_q;
   assign step_pulses = step_pulses_q;

endmodule

// File: tb/tb_ppt_sequencer.sv
// Scoreboarded bench: each valid step's expected profile is queued at start
// and compared when the sequencer leaves RUN for GAP.
module tb_ppt_sequencer;

   localparam int NS = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [1:0]    cfg_step;
   logic [1:0]    cfg_field;
   logic [CW-1:0] cfg_data;
   logic [1:0]    num_steps_m1;
   logic          loop_en;
   logic          start;
   logic          abort;
   logic          pulse_in;
   logic          pg_run;
   logic [CW-1:0] pg_period;
   logic [CW-1:0] pg_width;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    cur_step;
   logic [CW-1:0] step_pulses;

   logic pulse_man  = 1'b0;
   logic pulse_auto = 1'b0;
   logic auto_en    = 1'b0;
   assign pulse_in = pulse_man | pulse_auto;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int step;
      int period;
      int width;
      int count;
   } rec_t;
   rec_t exp_q[$];

   int m_p[NS];
   int m_w[NS];
   int m_c[NS];

   ppt_sequencer #(.NUM_STEPS(NS), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_step     (cfg_step),
      .cfg_field    (cfg_field),
      .cfg_data     (cfg_data),
      .num_steps_m1 (num_steps_m1),
      .loop_en      (loop_en),
      .start        (start),
      .abort        (abort),
      .pulse_in     (pulse_in),
      .pg_run       (pg_run),
      .pg_period    (pg_period),
      .pg_width     (pg_width),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .cur_step     (cur_step),
      .step_pulses  (step_pulses)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int s, input int f, input int d);
      cfg_we    = 1'b1;
      cfg_step  = 2'(s);
      cfg_field = 2'(f);
      cfg_data  = CW'(d);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic set_slot(input int s, input int p, input int w, input int c);
      cfg_write(s, 0, p);
      cfg_write(s, 1, w);
      cfg_write(s, 2, c);
      m_p[s] = p;
      m_w[s] = w;
      m_c[s] = c;
   endtask

   task automatic push_program(input int nsm1);
      for (int i = 0; i <= nsm1; i++) begin
         if (m_c[i] != 0 && m_w[i] != 0 && m_w[i] < m_p[i])
            exp_q.push_back('{i, m_p[i], m_w[i], m_c[i]});
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done) break;
         tick();
      end
      check_val(tag, done, 1);
   endtask

   task automatic wait_run(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pg_run) break;
         tick();
      end
      check_val(tag, pg_run, 1);
   endtask

   task automatic run_prog(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val({tag, "_done_clr"}, done, 0);
      wait_done({tag, "_done"}, 300);
   endtask

   // Free-running stand-in for the generator: one-cycle pulse every 3 cycles while enabled.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_en && pg_run) begin
            pulse_auto = (ph == 0);
            ph = (ph + 1) % 3;
         end else begin
            pulse_auto = 1'b0;
            ph = 0;
         end
      end
   end

   logic prev_run = 1'b0;
   always @(negedge clk) begin
      rec_t r;
      if (prev_run && !pg_run && busy) begin
         if (exp_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
         end else begin
            r = exp_q.pop_front();
            check_val("sb_step",   cur_step,    r.step);
            check_val("sb_period", pg_period,   r.period);
            check_val("sb_width",  pg_width,    r.width);
            check_val("sb_pulses", step_pulses, r.count);
         end
      end
      prev_run = pg_run;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_step = '0; cfg_field = '0; cfg_data = '0;
      num_steps_m1 = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < NS; i++) begin m_p[i] = 0; m_w[i] = 0; m_c[i] = 0; end
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_pg_run", pg_run, 0);
      check_val("rst_period", pg_period, 0);
      check_val("rst_width", pg_width, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_cur_step", cur_step, 0);
      check_val("rst_pulses", step_pulses, 0);

      // Single step with hand-driven pulse edges and exact latencies
      set_slot(0, 10, 3, 4);
      num_steps_m1 = 2'd0;
      push_program(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t1_load_run", pg_run, 0);
      check_val("t1_load_busy", busy, 1);
      tick();
      check_val("t1_run", pg_run, 1);
      check_val("t1_period", pg_period, 10);
      check_val("t1_width", pg_width, 3);
      for (int k = 1; k <= 4; k++) begin
         pulse_man = 1'b1;
         tick();
         pulse_man = 1'b0;
         check_val("t1_pulse_cnt", step_pulses, k);
         if (k < 4) tick();
      end
      check_val("t1_gap_run", pg_run, 0);
      check_val("t1_gap_busy", busy, 1);
      check_val("t1_gap_done", done, 0);
      tick();
      check_val("t1_fin_done", done, 0);
      check_val("t1_fin_busy", busy, 1);
      tick();
      check_val("t1_done", done, 1);
      check_val("t1_idle", busy, 0);
      check_val("t1_sb_left", exp_q.size(), 0);

      // Two valid steps back to back
      auto_en = 1'b1;
      set_slot(0, 8, 2, 2);
      set_slot(1, 20, 5, 3);
      num_steps_m1 = 2'd1;
      push_program(1);
      run_prog("t2");
      check_val("t2_err", err, 0);
      check_val("t2_run_off", pg_run, 0);
      check_val("t2_sb_left", exp_q.size(), 0);

      // Invalid and empty steps are skipped in one LOAD cycle each
      set_slot(0, 6, 6, 1);
      set_slot(1, 10, 3, 0);
      set_slot(2, 12, 4, 1);
      cfg_write(2, 3, 0);
      num_steps_m1 = 2'd2;
      push_program(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t3_load0_step", cur_step, 0);
      check_val("t3_load0_err", err, 0);
      tick();
      check_val("t3_load1_step", cur_step, 1);
      check_val("t3_err_set", err, 1);
      check_val("t3_load1_run", pg_run, 0);
      tick();
      check_val("t3_load2_step", cur_step, 2);
      check_val("t3_load2_run", pg_run, 0);
      tick();
      check_val("t3_run", pg_run, 1);
      check_val("t3_period", pg_period, 12);
      check_val("t3_width", pg_width, 4);
      wait_done("t3_done", 300);
      check_val("t3_err_sticky", err, 1);
      check_val("t3_sb_left", exp_q.size(), 0);

      // Looping program, then abort mid-RUN
      set_slot(0, 8, 2, 2);
      set_slot(1, 20, 5, 3);
      num_steps_m1 = 2'd1;
      loop_en = 1'b1;
      push_program(1);
      push_program(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t4_err_clr", err, 0);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() <= 2) break;
         tick();
      end
      check_val("t4_wrap_reached", exp_q.size(), 2);
      wait_run("t4_rerun", 20);
      check_val("t4_wrap_step", cur_step, 0);
      check_val("t4_wrap_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("t4_abort_run", pg_run, 0);
      check_val("t4_abort_busy", busy, 0);
      check_val("t4_abort_done", done, 0);
      check_val("t4_sb_pending", exp_q.size(), 2);
      exp_q.delete();
      loop_en = 1'b0;

      // Rewrite active slot during RUN; start while busy; start+abort in IDLE
      set_slot(0, 10, 3, 4);
      num_steps_m1 = 2'd0;
      push_program(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_val("t5_run", pg_run, 1);
      cfg_write(0, 0, 30);
      m_p[0] = 30;
      check_val("t5_period_held", pg_period, 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t5_start_ign_busy", busy, 1);
      check_val("t5_start_ign_step", cur_step, 0);
      check_val("t5_start_ign_period", pg_period, 10);
      wait_done("t5_done", 300);
      check_val("t5_sb_left", exp_q.size(), 0);
      push_program(0);
      run_prog("t5b");
      check_val("t5b_sb_left", exp_q.size(), 0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_val("t5_collide_busy", busy, 0);
      check_val("t5_collide_done", done, 1);

      // Reset mid-RUN clears outputs and the step table
      set_slot(0, 10, 3, 4);
      push_program(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_run("t6_run", 10);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NS; i++) begin m_p[i] = 0; m_w[i] = 0; m_c[i] = 0; end
      check_val("t6_pg_run", pg_run, 0);
      check_val("t6_period", pg_period, 0);
      check_val("t6_width", pg_width, 0);
      check_val("t6_busy", busy, 0);
      check_val("t6_done", done, 0);
      check_val("t6_err", err, 0);
      check_val("t6_cur_step", cur_step, 0);
      check_val("t6_pulses", step_pulses, 0);
      num_steps_m1 = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t6_load_busy", busy, 1);
      tick();
      check_val("t6_fin_run", pg_run, 0);
      check_val("t6_fin_done", done, 0);
      tick();
      check_val("t6_empty_done", done, 1);
      check_val("t6_empty_err", err, 0);
      check_val("t6_empty_period", pg_period, 0);
      check_val("t6_sb_left", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ppt_sequencer.md
# ppt_sequencer

Multi-step pulse-train sequencer sitting between the register map and the pulse generator, in the divided-clock domain. Holds a small table of step profiles (period, width, pulse count) and runs them in order: drives the generator's run/period/width inputs, counts emitted pulses, advances to the next step, and reports completion. It replaces the single static run bit with a scheduled burst program, optionally looped.

## Interface
- NUM_STEPS, 4, number of step slots (power of two, 2..8)
- CNT_W, 16, width of period, width and count fields
- clk  in  1  divided PPT clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe for the step table
- cfg_step  in  log2(NUM_STEPS)  target slot
- cfg_field  in  2  0=period, 1=width, 2=count, 3=reserved (write ignored)
- cfg_data  in  CNT_W  write value
- num_steps_m1  in  log2(NUM_STEPS)  last step index of the program
- loop_en  in  1  restart at step 0 after last step instead of finishing
- start  in  1  single-cycle start request
- abort  in  1  single-cycle stop request
- pulse_in  in  1  generator pulse output, sampled
- pg_run  out  1  generator run enable
- pg_period  out  CNT_W  period for the active step
- pg_width  out  CNT_W  width for the active step
- busy  out  1  high in any state but IDLE
- done  out  1  sticky completion flag
- err  out  1  sticky: a step was skipped as invalid
- cur_step  out  log2(NUM_STEPS)  active step index
- step_pulses  out  CNT_W  pulses emitted in the active step

## Operation
- States: IDLE, LOAD, RUN, GAP, FIN.
- IDLE: on start → LOAD with cur_step=0; clear done, err, step_pulses.
- LOAD: latch the slot's period/width/count into the active registers, then check validity.
  - count==0 → skip the step, no err.
  - width==0 or width>=period → skip the step, set err.
  - Otherwise → RUN.
  - A skipped step follows the GAP exit rule directly; it spends only its LOAD cycle.
- RUN: pg_run=1. Rising edge of pulse_in (pulse_in & ~pulse_in_q) increments step_pulses. The increment that reaches count → GAP.
- GAP: pg_run=0 for exactly one cycle so the generator restarts its phase.
  - Not the last step: cur_step+1, clear step_pulses, → LOAD.
  - Last step (cur_step==num_steps_m1) with loop_en: cur_step=0 → LOAD.
  - Last step without loop_en → FIN.
- FIN: set done, → IDLE.
- abort in any non-IDLE state → IDLE next cycle. pg_run drops that cycle; done is not set.
- abort has priority over every other transition.
- start while busy is ignored. start and abort in the same cycle in IDLE: stay IDLE.
- Step table writes are accepted in any state. A write to the active slot does not affect the running step; it takes effect at that slot's next LOAD.
- num_steps_m1 and loop_en are sampled at each GAP decision.
- All arithmetic is unsigned CNT_W; step_pulses never wraps (terminates at count).
- Step table resets to all zeros.

## Timing
- Reset values: pg_run=0, pg_period=0, pg_width=0, busy=0, done=0, err=0, cur_step=0, step_pulses=0; state IDLE; pulse_in_q=0.
- start sampled at cycle N → LOAD at N+1 → pg_run=1 from N+2.
- pg_period/pg_width are registered and valid from the cycle pg_run rises. They change only at LOAD.
- Pulse edge latency: pulse_in rising at cycle M increments step_pulses at M+1.
- Final-pulse edge at M → GAP at M+1 (pg_run=0) → LOAD at M+2 → next RUN at M+3.
- Last step: FIN at M+2, done=1 and busy=0 from M+3.
- Skipped step costs one cycle (LOAD only).
- done and err stay high until the next accepted start or rst.

## Structure
- Shared package ppt_pkg holds:
  - state enum (IDLE, LOAD, RUN, GAP, FIN)
  - field codes FIELD_PERIOD/FIELD_WIDTH/FIELD_COUNT
  - default CNT_W
- One sub-module, ppt_step_table: NUM_STEPS×3 register file with a write port and one combinational read port indexed by cur_step. The FSM, edge detector and counters stay in ppt_sequencer.

## Test plan
- Single step: slot0 period=10, width=3, count=4; num_steps_m1=0; start → pg_run high 2 cycles later; 4 pulse edges; GAP; done=1 three cycles after the 4th edge; pg_run low.
- Two steps: slot0 (8,2,2), slot1 (20,5,3); num_steps_m1=1 → pg_period 8 then 20; one-cycle pg_run gap between steps; cur_step 0→1; 5 pulses total; done.
- Invalid/skip: slot0 width=period=6, slot1 count=0, slot2 (12,4,1); num_steps_m1=2 → slots 0 and 1 take one LOAD cycle each; err=1; slot2 runs; done=1.
- Loop plus abort: loop_en=1, two valid steps → cur_step wraps 1→0, busy stays high; abort mid-RUN → pg_run=0 and busy=0 next cycle, done=0.
- Mid-run config and start collision: rewrite the active slot's period during RUN → pg_period unchanged until the next LOAD of that slot; start during RUN ignored; start+abort in IDLE → no transition.
- Reset mid-RUN: assert rst → all outputs at reset values the next cycle; step table cleared.
